// File: rtl/burst_pattern_generator.sv
// Debounced push-button burst generator: header, payload, optional XOR trailer, then an idle gap.
// Define BURST_PATTERN_CHECKSUM_EN to include the TRAILER state and checksum register.
module burst_pattern_generator #(
  parameter int DEBOUNCE_CYCLES = 80000,
  parameter int BURST_LEN       = 1024,
  parameter int GAP_CYCLES      = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        trigger_in,
  input  logic        hold_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        busy_out,
  output logic [15:0] seq_out
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0]     LAST_IDX = 16'(BURST_LEN - 1);
  localparam logic [15:0]     GAP_LAST = 16'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

`ifdef BURST_PATTERN_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    TRAILER = 3'd3,
    GAP     = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HEADER  = 3'd1,
    PAYLOAD = 3'd2,
    GAP     = 3'd4
  } state_t;
`endif

  // Trigger synchronizer and debouncer.
  logic            sync1, sync2, db_level, db_level_q;
  logic [DB_W-1:0] db_cnt;
  logic            start;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      db_level   <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt     <= '0;
    end else begin
      sync1      <= trigger_in;
      sync2      <= sync1;
      db_level_q <= db_level;
      if (sync2 != db_level) begin
        if (db_cnt == DB_LAST) begin
          db_level <= ~db_level;
          db_cnt   <= '0;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  assign start = db_level & ~db_level_q;

  // Output handshake: valid_out=1 presents data_out for exactly one cycle. hold_in is sampled
  // on the edge that would present the next word; when 1 that edge produces a bubble and the
  // FSM, index and checksum stay put, so the next word appears once hold_in drops.
  state_t      state, state_n;
  logic [31:0] data_n;
  logic        valid_n;
  logic [15:0] idx, idx_n, idx_inc;
  logic [15:0] gap_cnt, gap_n;
  logic [15:0] seq, seq_n;
`ifdef BURST_PATTERN_CHECKSUM_EN
  logic [31:0] csum, csum_n;
`endif

  assign idx_inc = idx + 16'd1;

  always_comb begin
    state_n = state;
    data_n  = data_out;
    valid_n = 1'b0;
    idx_n   = idx;
    gap_n   = gap_cnt;
    seq_n   = seq;
`ifdef BURST_PATTERN_CHECKSUM_EN
    csum_n  = csum;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          state_n = HEADER;
          data_n  = {16'hA5A5, seq};
          valid_n = 1'b1;
          idx_n   = 16'd0;
`ifdef BURST_PATTERN_CHECKSUM_EN
          csum_n  = {16'hA5A5, seq};
`endif
        end
      end
      HEADER: begin
        if (!hold_in) begin
          state_n = PAYLOAD;
          data_n  = {seq, 16'd0};
          valid_n = 1'b1;
          idx_n   = 16'd0;
`ifdef BURST_PATTERN_CHECKSUM_EN
          csum_n  = csum ^ {seq, 16'd0};
`endif
        end
      end
      PAYLOAD: begin
        // idx is the index of the payload word currently on data_out.
        if (!hold_in) begin
          if (idx == LAST_IDX) begin
`ifdef BURST_PATTERN_CHECKSUM_EN
            state_n = TRAILER;
            data_n  = csum;
            valid_n = 1'b1;
`else
            state_n = GAP;
            gap_n   = 16'd0;
            seq_n   = seq + 16'd1;
`endif
          end else begin
            idx_n   = idx_inc;
            data_n  = {seq, idx_inc};
            valid_n = 1'b1;
`ifdef BURST_PATTERN_CHECKSUM_EN
            csum_n  = csum ^ {seq, idx_inc};
`endif
          end
        end
      end
`ifdef BURST_PATTERN_CHECKSUM_EN
      TRAILER: begin
        if (!hold_in) begin
          state_n = GAP;
          gap_n   = 16'd0;
          seq_n   = seq + 16'd1;
        end
      end
`endif
      GAP: begin
        // GAP_CYCLES of 0 and 1 both spend exactly one cycle here.
        if (gap_cnt == GAP_LAST) begin
          state_n = IDLE;
        end else begin
          gap_n = gap_cnt + 16'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      data_out  <= 32'h0;
      valid_out <= 1'b0;
      idx       <= 16'd0;
      gap_cnt   <= 16'd0;
      seq       <= 16'd0;
`ifdef BURST_PATTERN_CHECKSUM_EN
      csum      <= 32'h0;
`endif
    end else begin
      state     <= state_n;
      data_out  <= data_n;
      valid_out <= valid_n;
      idx       <= idx_n;
      gap_cnt   <= gap_n;
      seq       <= seq_n;
`ifdef BURST_PATTERN_CHECKSUM_EN
      csum      <= csum_n;
`endif
    end
  end

  assign busy_out = (state != IDLE);
  assign seq_out  = seq;

endmodule

// File: tb/tb_burst_pattern_generator.sv
// Self-checking bench for burst_pattern_generator: word-queue reference model, per-cycle
// compare process, directed scenarios with literal expectations, then randomized traffic.
module tb_burst_pattern_generator;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int BURST_LEN       = 4;
  localparam int GAP_CYCLES      = 2;
`ifdef BURST_PATTERN_CHECKSUM_EN
  localparam int WPB = BURST_LEN + 2;
`else
  localparam int WPB = BURST_LEN + 1;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        trigger_in = 1'b0;
  logic        hold_in = 1'b0;
  logic [31:0] data_out;
  logic        valid_out;
  logic        busy_out;
  logic [15:0] seq_out;

  burst_pattern_generator #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .BURST_LEN(BURST_LEN),
    .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .trigger_in(trigger_in),
    .hold_in(hold_in),
    .data_out(data_out),
    .valid_out(valid_out),
    .busy_out(busy_out),
    .seq_out(seq_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  checking = 1'b0;

  always @(posedge clk_in) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Burst = list of words built up front; hold only inserts bubbles between pops.
  bit          m_s1, m_s2, m_db, m_db_q;
  int          m_run;
  bit          m_in_burst;
  int          m_gap_left;
  logic [15:0] m_seq;
  logic [31:0] m_data;
  bit          m_valid;
  logic [31:0] m_words[$];

  always @(posedge clk_in) begin : model
    bit          start;
    logic [31:0] x;
    if (rst_in) begin
      m_s1 = 0; m_s2 = 0; m_db = 0; m_db_q = 0; m_run = 0;
      m_in_burst = 0; m_gap_left = 0; m_seq = 16'h0; m_data = 32'h0; m_valid = 0;
      m_words.delete();
    end else begin
      start   = m_db && !m_db_q;
      m_valid = 0;
      if (m_in_burst) begin
        if (!hold_in) begin
          if (m_words.size() > 0) begin
            m_data  = m_words.pop_front();
            m_valid = 1;
          end else begin
            m_in_burst = 0;
            m_gap_left = (GAP_CYCLES > 0) ? GAP_CYCLES : 1;
            m_seq      = m_seq + 16'd1;
          end
        end
      end else if (m_gap_left > 0) begin
        m_gap_left--;
      end else if (start) begin
        m_words.delete();
        m_words.push_back({16'hA5A5, m_seq});
        for (int i = 0; i < BURST_LEN; i++) m_words.push_back({m_seq, 16'(i)});
`ifdef BURST_PATTERN_CHECKSUM_EN
        x = 32'h0;
        foreach (m_words[k]) x = x ^ m_words[k];
        m_words.push_back(x);
`endif
        m_data     = m_words.pop_front();
        m_valid    = 1;
        m_in_burst = 1;
      end
      m_db_q = m_db;
      if (m_s2 != m_db) begin
        m_run++;
        if (m_run == DEBOUNCE_CYCLES) begin
          m_db  = !m_db;
          m_run = 0;
        end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = trigger_in;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk_in) begin
    if (checking) begin
      check("valid_out", 32'(valid_out), 32'(m_valid));
      check("busy_out", 32'(busy_out), 32'(m_in_burst || (m_gap_left > 0)));
      check("seq_out", 32'(seq_out), 32'(m_seq));
      check("data_out", data_out, m_data);
    end
  end

  // ---------------- capture for literal checks ----------------
  logic [31:0] cap_q[$];
  int          cap_t[$];
  logic [31:0] exp_q[$];
  bit          busy_seen, busy_q;
  int          busy_fall_t;

  always @(negedge clk_in) begin
    if (checking) begin
      if (valid_out) begin
        cap_q.push_back(data_out);
        cap_t.push_back(cyc);
      end
      if (busy_out) busy_seen = 1'b1;
      if (busy_q && !busy_out) busy_fall_t = cyc;
      busy_q = busy_out;
    end
  end

  function automatic logic [31:0] cap_at(input int i);
    return (i < cap_q.size()) ? cap_q[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic int time_at(input int i);
    return (i < cap_t.size()) ? cap_t[i] : -1000;
  endfunction

  task automatic clear_capture();
    cap_q.delete();
    cap_t.delete();
    busy_seen   = 1'b0;
    busy_q      = busy_out;
    busy_fall_t = -1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk_in);
    rst_in = 1'b1; trigger_in = 1'b0; hold_in = 1'b0;
    repeat (2) @(negedge clk_in);
    rst_in   = 1'b0;
    checking = 1'b1;
  endtask

  task automatic press(input int n);
    trigger_in = 1'b1;
    repeat (n) @(negedge clk_in);
    trigger_in = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    repeat (5) @(negedge clk_in);
    while (busy_out && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check("idle_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic wait_word(input logic [31:0] w, input int budget);
    int n = 0;
    while (!(valid_out && data_out == w) && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    check("word_timeout", 32'(n < budget), 32'd1);
  endtask

  task automatic build_exp0();
    exp_q.delete();
    exp_q.push_back(32'hA5A5_0000);
    exp_q.push_back(32'h0000_0000);
    exp_q.push_back(32'h0000_0001);
    exp_q.push_back(32'h0000_0002);
    exp_q.push_back(32'h0000_0003);
`ifdef BURST_PATTERN_CHECKSUM_EN
    exp_q.push_back(32'hA5A5_0000);
`endif
  endtask

  // ---------------- scenarios ----------------
  initial begin
    do_reset();
    check("reset_valid", 32'(valid_out), 32'd0);
    check("reset_busy", 32'(busy_out), 32'd0);
    check("reset_seq", 32'(seq_out), 32'd0);
    check("reset_data", data_out, 32'h0);

    // Clean press: one full burst with literal words and gap timing.
    clear_capture();
    press(20);
    wait_idle(100);
    build_exp0();
    check("t1_count", 32'(cap_q.size()), 32'(WPB));
    foreach (exp_q[i]) check($sformatf("t1_word%0d", i), cap_at(i), exp_q[i]);
    check("t1_contiguous", 32'(time_at(WPB - 1) - time_at(0)), 32'(WPB - 1));
    check("t1_busy_fall", 32'(busy_fall_t - time_at(WPB - 1)), 32'd3);
    check("t1_seq", 32'(seq_out), 32'd1);

    // Short glitches never reach the debounced level.
    do_reset();
    clear_capture();
    for (int n = 1; n <= 3; n++) begin
      press(n);
      repeat (10) @(negedge clk_in);
    end
    check("t2_no_valid", 32'(cap_q.size()), 32'd0);
    check("t2_no_busy", 32'(busy_seen), 32'd0);

    // Two-cycle hold while word 1 is pending.
    do_reset();
    clear_capture();
    trigger_in = 1'b1;
    wait_word(32'h0000_0000, 40);
    hold_in = 1'b1;
    repeat (2) @(negedge clk_in);
    hold_in = 1'b0;
    repeat (10) @(negedge clk_in);
    trigger_in = 1'b0;
    wait_idle(100);
    build_exp0();
    check("t3_count", 32'(cap_q.size()), 32'(WPB));
    foreach (exp_q[i]) check($sformatf("t3_word%0d", i), cap_at(i), exp_q[i]);
    check("t3_bubble", 32'(time_at(2) - time_at(1)), 32'd3);
    check("t3_resume", 32'(time_at(3) - time_at(2)), 32'd1);

    // Release and re-press during a held PAYLOAD is dropped; a later press starts seq 1.
    do_reset();
    clear_capture();
    trigger_in = 1'b1;
    wait_word(32'h0000_0000, 40);
    hold_in = 1'b1;
    repeat (3) @(negedge clk_in);
    trigger_in = 1'b0;
    repeat (12) @(negedge clk_in);
    trigger_in = 1'b1;
    repeat (12) @(negedge clk_in);
    hold_in = 1'b0;
    wait_idle(100);
    trigger_in = 1'b0;
    repeat (12) @(negedge clk_in);
    press(12);
    wait_idle(100);
    check("t4_count", 32'(cap_q.size()), 32'(2 * WPB));
    check("t4_first_hdr", cap_at(0), 32'hA5A5_0000);
    check("t4_second_hdr", cap_at(WPB), 32'hA5A5_0001);
    check("t4_second_p3", cap_at(WPB + 4), 32'h0001_0003);
    check("t4_seq", 32'(seq_out), 32'd2);

    // Reset mid-PAYLOAD truncates the burst; the next press restarts at seq 0.
    do_reset();
    clear_capture();
    trigger_in = 1'b1;
    wait_word(32'h0000_0001, 40);
    rst_in = 1'b1;
    trigger_in = 1'b0;
    @(negedge clk_in);
    rst_in = 1'b0;
    check("t5_valid", 32'(valid_out), 32'd0);
    check("t5_busy", 32'(busy_out), 32'd0);
    check("t5_seq", 32'(seq_out), 32'd0);
    check("t5_data", data_out, 32'h0);
    repeat (10) @(negedge clk_in);
    check("t5_no_resume", 32'(valid_out | busy_out), 32'd0);
    clear_capture();
    press(20);
    wait_idle(100);
    check("t5_count", 32'(cap_q.size()), 32'(WPB));
    check("t5_hdr", cap_at(0), 32'hA5A5_0000);

    // Randomized trigger, hold and occasional reset against the model.
    do_reset();
    for (int it = 0; it < 400; it++) begin
      trigger_in = 1'($urandom_range(0, 1));
      hold_in    = ($urandom_range(0, 3) == 0);
      rst_in     = ($urandom_range(0, 149) == 0);
      repeat ($urandom_range(1, 10)) @(negedge clk_in);
    end
    rst_in = 1'b0; trigger_in = 1'b0; hold_in = 1'b0;
    wait_idle(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/burst_pattern_generator.md
BURST_PATTERN_GENERATOR -- requirements
Module: burst_pattern_generator

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 80000, which is the number of consecutive stable synchronized trigger samples needed to change the debounced level (1 ms at 80 MHz).
REQ-002 The block SHALL have parameter BURST_LEN, default 1024, which is the number of payload words per burst; the legal range is 1..65536.
REQ-003 The block SHALL have parameter GAP_CYCLES, default 16, which is the number of idle cycles enforced after each burst; the legal range is 0..65535.
REQ-004 The block SHALL have port clk_in, input, 1 bit: the single clock (80 MHz generation domain); all logic is on its rising edge.
REQ-005 The block SHALL have port rst_in, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port trigger_in, input, 1 bit: the raw asynchronous push-button level.
REQ-007 The block SHALL have port hold_in, input, 1 bit: downstream gateway FIFO almost-full; while it is 1, generation stalls.
REQ-008 The block SHALL have port data_out, output, 32 bits: the generated word, which is registered.
REQ-009 The block SHALL have port valid_out, output, 1 bit: data_out is valid this cycle, which is registered.
REQ-010 The block SHALL have port busy_out, output, 1 bit: high whenever the FSM is not in IDLE.
REQ-011 The block SHALL have port seq_out, output, 16 bits: the current burst sequence number.

Function
REQ-012 trigger_in SHALL pass through a 2-flop synchronizer before any other use.
REQ-013 The debouncer SHALL work as follows:
- A counter increments each cycle in which the synchronized level differs from the debounced level, and clears otherwise.
- When the counter reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
REQ-014 A start request SHALL be a 0->1 transition of the debounced level, one cycle wide; it is honoured only in IDLE and is dropped (not queued) in every other state.
REQ-015 The FSM SHALL have states IDLE, HEADER, PAYLOAD, TRAILER and GAP, with these transitions:
- IDLE->HEADER on a start request.
- HEADER->PAYLOAD after the header word is emitted.
- PAYLOAD->TRAILER after word BURST_LEN-1 is emitted.
- TRAILER->GAP after the trailer word is emitted.
- GAP->IDLE after GAP_CYCLES cycles, or on the next cycle if GAP_CYCLES=0.
REQ-016 The header word SHALL be {16'hA5A5, seq}.
REQ-017 Payload word i (i=0..BURST_LEN-1) SHALL be {seq, i[15:0]}; the index wraps 16'hFFFF->0 only when BURST_LEN=65536.
REQ-018 The trailer word SHALL be the bitwise XOR of the header and all payload words of the same burst.
REQ-019 valid_out SHALL rise on the cycle after the start request, carrying the header; with hold_in=0, a burst is a contiguous run of valid_out=1.
REQ-020 hold_in sampled 1 in HEADER, PAYLOAD or TRAILER SHALL have these effects:
- valid_out is 0 on the next cycle.
- The state, index and checksum do not advance.
- The pending word is emitted unchanged after hold_in returns to 0.
- No word is lost or duplicated.
REQ-021 hold_in SHALL have no effect in IDLE or GAP; the GAP count proceeds regardless of hold_in.
REQ-022 valid_out SHALL be 0 in IDLE and GAP, and data_out SHALL hold its last value whenever valid_out=0.
REQ-023 seq SHALL increment by 1 on the TRAILER->GAP transition and wrap 16'hFFFF->16'h0000.
REQ-024 The debouncer SHALL continue to track the button in all states, so a release/press during a burst has no effect on the burst.

Reset
REQ-025 With rst_in=1 at a rising clock edge, the following SHALL hold on the next cycle, including when rst_in is asserted mid-burst or mid-hold:
- State=IDLE.
- valid_out=0, data_out=32'h0, busy_out=0, seq_out=16'h0.
- Debounced level=0, debounce counter=0, synchronizer flops=0.
- Payload index=0, checksum=0, gap counter=0.
REQ-026 A truncated burst SHALL NOT be resumed after reset.

Configuration
REQ-027 The macro BURST_PATTERN_CHECKSUM_EN, when defined, SHALL include the TRAILER state and checksum register, giving BURST_LEN+2 words per burst.
REQ-028 When BURST_PATTERN_CHECKSUM_EN is undefined, there SHALL be no TRAILER state and no checksum logic, giving BURST_LEN+1 words per burst:
- PAYLOAD->GAP on the last payload word.
- seq increments on the PAYLOAD->GAP transition.

Verification (DEBOUNCE_CYCLES=4, BURST_LEN=4, GAP_CYCLES=2 unless stated)
REQ-029 Clean press held 20 cycles, macro defined -> 6 consecutive valid words: A5A50000, 00000000, 00000001, 00000002, 00000003, trailer A5A50000; then valid_out=0, busy_out low 3 cycles after the trailer, seq_out=1.
REQ-030 trigger_in pulses of 1, 2 and 3 cycles -> no start request, valid_out stays 0, busy_out stays 0.
REQ-031 hold_in=1 for 2 cycles while word 00000001 is pending -> 2-cycle valid gap, then 00000001, 00000002, 00000003 with the trailer still A5A50000.
REQ-032 Release and re-press during PAYLOAD -> ignored; a press after return to IDLE -> header A5A50001.
REQ-033 rst_in=1 for one cycle during PAYLOAD -> next cycle valid_out=0, busy_out=0, seq_out=0; the next press gives header A5A50000.
REQ-034 Macro undefined, clean press -> exactly 5 valid words A5A50000, 00000000..00000003, with no trailer.
